// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared
// JK register bank; each operation runs IDLE -> GRANT -> APPLY -> DONE.
module jk_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] mask,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             done_id,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_not
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_APPLY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_idx;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_q;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_done_id;

  logic             w_found;
  logic [2:0]       w_win;
  logic [2:0]       w_ptr_next;
  logic [N_REQ-1:0] w_onehot;
  logic [WIDTH-1:0] w_q_next;

  // Search upward from r_ptr, wrapping at N_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      int c;
      c = int'(r_ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!w_found && req[c]) begin
        w_found = 1'b1;
        w_win   = 3'(c);
      end
    end
  end

  assign w_ptr_next = (w_win == 3'(N_REQ - 1)) ? 3'd0 : w_win + 3'd1;
  assign w_onehot   = N_REQ'(1) << w_win;

  always_comb begin
    w_q_next = r_q;
    unique case (r_op)
      2'b00: w_q_next = r_q;
      2'b01: w_q_next = r_q & ~r_mask;
      2'b10: w_q_next = r_q | r_mask;
      2'b11: w_q_next = r_q ^ r_mask;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 3'd0;
      r_idx     <= 3'd0;
      r_op      <= 2'b00;
      r_mask    <= '0;
      r_q       <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 3'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= w_onehot;
            r_idx   <= w_win;
            r_busy  <= 1'b1;
            r_ptr   <= w_ptr_next;
          end
        end
        S_GRANT: begin
          r_op    <= op[2*int'(r_idx) +: 2];
          r_mask  <= mask[WIDTH*int'(r_idx) +: WIDTH];
          r_state <= S_APPLY;
        end
        S_APPLY: begin
          r_q       <= w_q_next;
          r_done    <= 1'b1;
          r_done_id <= r_idx;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign q       = r_q;
  assign q_not   = ~r_q;

endmodule
